lcd_spi_writer: RTL
===================

Name: lcd_spi_writer

Overview:
- Serial back-end for the LCD drawing path. Consumes one 9-bit word per handshake from the drawing/arbitration stage: bit 8 = D/C select, bits 7:0 = payload.
- Shifts the word out on a 4-wire SPI (mode 0, MSB first) and returns a one-cycle wr_done pulse, which upstream drawing blocks use to advance to their next word.

Parameters:
- CLK_DIV, 2: sys_clk cycles per SCLK half-period; legal range 1..255.
- HOLDOFF, 2: sys_clk cycles after wr_done during which en_write is ignored; legal range 0..15. Covers upstream registered-enable lag.

Ports:
- sys_clk, input, 1: system clock; all logic on rising edge.
- sys_rst_n, input, 1: asynchronous, active-low reset.
- data, input, 9: bit 8 = D/C (0 command, 1 data); bits 7:0 = byte to send.
- en_write, input, 1: level request; sampled only in IDLE.
- wr_done, output, 1: one-cycle pulse when a word has been fully transmitted.
- busy, output, 1: high in every state except IDLE.
- lcd_cs_n, output, 1: chip select, active low.
- lcd_dc, output, 1: D/C line, registered copy of the captured data[8].
- lcd_sclk, output, 1: SPI clock, idles low.
- lcd_mosi, output, 1: serial data.

Behaviour:
- Clock and reset: sys_clk; reset sys_rst_n, asynchronous, active-low. All outputs are registered.
- Reset values: lcd_cs_n=1, lcd_sclk=0, lcd_mosi=0, lcd_dc=0, wr_done=0, busy=0, state=IDLE, counters=0.
- Reset mid-transfer: everything returns to reset values immediately. The partial word is discarded and no wr_done is issued.
- States: IDLE, SETUP, SHIFT_HI, SHIFT_LO, FINISH, HOLD.
- IDLE:
  - On an edge k where en_write=1: latch data into the shift register and go to SETUP.
  - From edge k: lcd_cs_n=0, lcd_dc=data[8], lcd_mosi=data[7], busy=1.
- SETUP: hold for CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI: lcd_sclk=1 for CLK_DIV cycles; the slave samples on the rising edge. Then go to SHIFT_LO.
- SHIFT_LO:
  - lcd_sclk=0 for CLK_DIV cycles.
  - On entry, lcd_mosi advances to the next lower bit.
  - After bit 0's low phase, go to FINISH; otherwise go back to SHIFT_HI.
- Cycle timing, relative to capture edge k:
  - Rising SCLK for bit n (n=7..0) at edge k+(15-2n)*CLK_DIV.
  - Falling SCLK for bit n at edge k+(16-2n)*CLK_DIV.
- FINISH:
  - At edge k+17*CLK_DIV: lcd_cs_n=1 and wr_done=1 for exactly one cycle; lcd_mosi=0.
  - Then go to HOLD, or to IDLE if HOLDOFF=0.
  - With defaults, wr_done is high in the cycle after edge k+34.
- HOLD: HOLDOFF cycles with busy=1 and en_write ignored, then IDLE.
  - Earliest next capture edge is k+17*CLK_DIV+1+HOLDOFF.
- Ignored inputs: en_write and data changes while busy have no effect. The shift register is the only source of transmitted bits.
- lcd_dc is stable from capture until the next capture. It is not returned to 0 at FINISH.
- Exactly 8 SCLK rising edges per word; lcd_sclk is never high while lcd_cs_n=1.
- One bit counter (3 bits) and one divider counter (8 bits). The divider reloads on every state change; no wrap beyond CLK_DIV-1.

Test Plan:
- Command word: data=9'h02A, en_write pulsed 1 cycle, defaults -> lcd_dc=0; MOSI at 8 rising SCLK edges = 0,0,1,0,1,0,1,0; wr_done single pulse at edge k+34; lcd_cs_n=1 from then.
- Data word: data=9'h1BC -> lcd_dc=1; sampled bits 1,0,1,1,1,1,0,0; busy high from edge k until HOLD ends (edge k+37).
- Held request: en_write held high, data switched to 9'h155 the cycle after wr_done -> no capture before edge k+37. Second transfer sends 0x55 with lcd_dc=1. Exactly two wr_done pulses.
- Input change while busy: data toggled every cycle during a transfer of 9'h0FF -> all 8 sampled bits = 1; lcd_dc=0.
- Reset mid-transfer: assert sys_rst_n low after the 4th rising SCLK -> outputs at reset values immediately. No wr_done. Next request after release transmits cleanly.
- Parameter variant CLK_DIV=1, HOLDOFF=0: data=9'h0A5 -> SCLK period 2 cycles; wr_done at edge k+17; new capture possible at edge k+18.

Source files
------------

// File: rtl/lcd_spi_writer.sv
// SPI (mode 0, MSB first) serializer for 9-bit LCD words: bit 8 drives D/C, bits 7:0 are shifted out.
// Each word ends with a one-cycle wr_done pulse, then a short hold-off before the next request is taken.
module lcd_spi_writer #(
  parameter int CLK_DIV = 2,
  parameter int HOLDOFF = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [8:0] data,
  input  logic       en_write,
  output logic       wr_done,
  output logic       busy,
  output logic       lcd_cs_n,
  output logic       lcd_dc,
  output logic       lcd_sclk,
  output logic       lcd_mosi
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SETUP    = 3'd1;
  localparam logic [2:0] SHIFT_HI = 3'd2;
  localparam logic [2:0] SHIFT_LO = 3'd3;
  localparam logic [2:0] FINISH   = 3'd4;
  localparam logic [2:0] HOLD     = 3'd5;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_LAST = (HOLDOFF > 0) ? 8'(HOLDOFF - 1) : 8'd0;

  logic [2:0] state;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       div_done;
  logic       accept_ok;

  assign div_done = (div_cnt == DIV_LAST);

  // The edge that ends the hold-off window may already take the next word,
  // so back-to-back requests lose no extra cycle.
  always_comb begin
    accept_ok = 1'b0;
    case (state)
      IDLE:    accept_ok = 1'b1;
      FINISH:  accept_ok = (HOLDOFF == 0);
      HOLD:    accept_ok = (div_cnt == HOLD_LAST);
      default: accept_ok = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      wr_done   <= 1'b0;
      busy      <= 1'b0;
      lcd_cs_n  <= 1'b1;
      lcd_dc    <= 1'b0;
      lcd_sclk  <= 1'b0;
      lcd_mosi  <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      if (accept_ok && en_write) begin
        state     <= SETUP;
        div_cnt   <= '0;
        bit_cnt   <= '0;
        shift_reg <= data[7:0];
        busy      <= 1'b1;
        lcd_cs_n  <= 1'b0;
        lcd_dc    <= data[8];
        lcd_mosi  <= data[7];
      end else begin
        case (state)
          IDLE: begin
          end
          SETUP: begin
            if (div_done) begin
              state    <= SHIFT_HI;
              div_cnt  <= '0;
              lcd_sclk <= 1'b1;
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end
          SHIFT_HI: begin
            if (div_done) begin
              state     <= SHIFT_LO;
              div_cnt   <= '0;
              lcd_sclk  <= 1'b0;
              shift_reg <= {shift_reg[6:0], 1'b0};
              lcd_mosi  <= shift_reg[6];
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end
          SHIFT_LO: begin
            if (div_done) begin
              div_cnt <= '0;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state    <= FINISH;
                lcd_cs_n <= 1'b1;
                lcd_mosi <= 1'b0;
                wr_done  <= 1'b1;
              end else begin
                state    <= SHIFT_HI;
                lcd_sclk <= 1'b1;
              end
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end
          FINISH: begin
            div_cnt <= '0;
            if (HOLDOFF == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= HOLD;
            end
          end
          HOLD: begin
            if (div_cnt == HOLD_LAST) begin
              state   <= IDLE;
              div_cnt <= '0;
              busy    <= 1'b0;
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
